// File: rtl/seq_mult32.sv
// Sequential unsigned 32x32 shift-add multiplier, low 32 bits of the product.
// One multiplier bit is consumed per clock; latency is fixed at 33 clocks after reset release.
module seq_mult32 (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] p_o,
  output logic        rdy_o
);

  // state      | meaning
  // IDLE_LOAD  | first edge after release: capture operands, clear accumulator
  // RUN        | 32 shift-add iterations
  // DONE       | result frozen, rdy high until reset
  localparam logic [1:0] S_IDLE_LOAD = 2'd0;
  localparam logic [1:0] S_RUN       = 2'd1;
  localparam logic [1:0] S_DONE      = 2'd2;

  logic [1:0]  state_q,  state_d;
  logic [31:0] mcand_q,  mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [31:0] acc_q,    acc_d;
  logic [5:0]  cnt_q,    cnt_d;
  logic        rdy_q,    rdy_d;

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    rdy_d    = rdy_q;
    case (state_q)
      S_IDLE_LOAD: begin
        mcand_d  = a_i;
        mplier_d = b_i;
        acc_d    = 32'd0;
        cnt_d    = 6'd0;
        rdy_d    = 1'b0;
        state_d  = S_RUN;
      end
      S_RUN: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = {mcand_q[30:0], 1'b0};
        mplier_d = {1'b0, mplier_q[31:1]};
        cnt_d    = cnt_q + 6'd1;
        // cnt_q == 31 means this is the 32nd RUN edge
        if (cnt_q == 6'd31) begin
          state_d = S_DONE;
          rdy_d   = 1'b1;
        end
      end
      S_DONE: begin
        rdy_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE_LOAD;
        rdy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE_LOAD;
      mcand_q  <= 32'd0;
      mplier_q <= 32'd0;
      acc_q    <= 32'd0;
      cnt_q    <= 6'd0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      rdy_q    <= rdy_d;
    end
  end

  assign p_o   = acc_q;
  assign rdy_o = rdy_q;

endmodule

// File: tb/tb_seq_mult32.sv
// Scoreboard bench for seq_mult32: stimulus pushes expected products, a monitor
// pops and checks them (value and 33-clock latency) each time rdy rises.
module tb_seq_mult32;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] p;
  logic        rdy;

  int n_vec  = 0;
  int n_fail = 0;

  logic [31:0] exp_q[$];
  int          edge_cnt;
  logic        rdy_prev;

  seq_mult32 dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .a_i     (a),
    .b_i     (b),
    .p_o     (p),
    .rdy_o   (rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // rising edges seen since the last reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  // monitor / scoreboard
  initial begin
    logic [31:0] e;
    rdy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rdy && !rdy_prev) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_rdy: rdy rose with no pending vector, p=%h", p);
        end else begin
          e = exp_q.pop_front();
          if (p !== e) begin
            n_fail++;
            $display("FAIL product: p=%h required %h", p, e);
          end
          n_vec++;
          if (edge_cnt != 33) begin
            n_fail++;
            $display("FAIL latency: rdy after %0d clocks, required 33", edge_cnt);
          end
        end
      end
      rdy_prev = rdy;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // hold reset at a negedge, load operands, release at the next negedge
  task automatic start(input logic [31:0] av, input logic [31:0] bv, input bit push, input logic [31:0] ev);
    @(negedge clk);
    rst_n = 1'b0;
    a = av;
    b = bv;
    @(negedge clk);
    if (push) exp_q.push_back(ev);
    rst_n = 1'b1;
  endtask

  task automatic wait_rdy(input string name);
    int k;
    k = 0;
    while (!rdy && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!rdy) begin
      n_vec++;
      n_fail++;
      $display("FAIL %s_timeout: rdy=%b after %0d cycles, required 1", name, rdy, k);
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] p;
  } vec_t;

  vec_t vecs[6] = '{
    '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001},
    '{32'h00010000, 32'h00010000, 32'h00000000},
    '{32'h00000000, 32'h12345678, 32'h00000000},
    '{32'h12345678, 32'h00000001, 32'h12345678},
    '{32'h80000000, 32'h00000003, 32'h80000000},
    '{32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF}
  };

  initial begin
    rst_n = 1'b0;
    a = 32'd0;
    b = 32'd0;
    #2;
    check("reset_p", p, 32'd0);
    check("reset_rdy", {31'd0, rdy}, 32'd0);

    // basic product with per-edge rdy checks and hold
    start(32'd3, 32'd5, 1'b1, 32'd15);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      check($sformatf("rdy_low_edge%0d", i), {31'd0, rdy}, 32'd0);
    end
    @(negedge clk);
    check("basic_rdy", {31'd0, rdy}, 32'd1);
    check("basic_p", p, 32'd15);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("hold_rdy%0d", i), {31'd0, rdy}, 32'd1);
      check($sformatf("hold_p%0d", i), p, 32'd15);
    end

    foreach (vecs[i]) begin
      start(vecs[i].a, vecs[i].b, 1'b1, vecs[i].p);
      wait_rdy($sformatf("vec%0d", i));
    end

    // inputs changed after the load edge and again in DONE
    start(32'd7, 32'd6, 1'b1, 32'd42);
    @(posedge clk);
    #1;
    a = 32'hDEAD;
    b = 32'hBEEF;
    wait_rdy("inchg");
    a = 32'h1234;
    b = 32'h5678;
    repeat (5) @(negedge clk);
    check("done_inchg_p", p, 32'd42);
    check("done_inchg_rdy", {31'd0, rdy}, 32'd1);

    // asynchronous abort after edge 10
    start(32'd1000, 32'd1000, 1'b0, 32'd0);
    repeat (11) @(posedge clk);
    #2;
    check("pre_abort_rdy", {31'd0, rdy}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("abort_p", p, 32'd0);
    check("abort_rdy", {31'd0, rdy}, 32'd0);
    a = 32'd12;
    b = 32'd12;
    @(negedge clk);
    exp_q.push_back(32'd144);
    rst_n = 1'b1;
    wait_rdy("after_abort");

    // abort from DONE
    #1;
    rst_n = 1'b0;
    #1;
    check("done_abort_p", p, 32'd0);
    check("done_abort_rdy", {31'd0, rdy}, 32'd0);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
